// File: rtl/idex_skid_reg_pkg.sv
// Shared widths, control-bit indices and state encoding for the ID/EX skid register.
package idex_skid_reg_pkg;

  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefRdW    = 6;
  localparam int unsigned DefAluOpW = 4;
  localparam int unsigned DefCtrlW  = 9;
  localparam int unsigned DefCntW   = 16;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_BRANCH_Z   = 1;
  localparam int unsigned CTRL_BRANCH_NEG = 2;
  localparam int unsigned CTRL_MEMTOREG   = 3;
  localparam int unsigned CTRL_PCTOREG    = 4;
  localparam int unsigned CTRL_MEM_R      = 5;
  localparam int unsigned CTRL_MEM_W      = 6;
  localparam int unsigned CTRL_JUMP       = 7;
  localparam int unsigned CTRL_JUMP_MEM   = 8;

  // Encoding is the valid pair {skid_valid, main_valid}; StIllegal must never be reached.
  typedef enum logic [1:0] {
    StEmpty   = 2'b00,
    StFull    = 2'b01,
    StIllegal = 2'b10,
    StSkid    = 2'b11
  } state_e;

  function automatic int unsigned payload_w(int unsigned dw, int unsigned rw, int unsigned aw,
                                            int unsigned cw);
    return 3 * dw + rw + aw + cw;
  endfunction

endpackage

// File: rtl/idex_skid_reg_if.sv
// Valid/ready beat carrying the ID/EX payload and control bundle.
interface idex_skid_reg_if
  import idex_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned RD_W    = DefRdW,
    parameter int unsigned ALUOP_W = DefAluOpW,
    parameter int unsigned CTRL_W  = DefCtrlW
);
    logic               valid;
    logic               ready;
    logic [DATA_W-1:0]  rs;
    logic [DATA_W-1:0]  rt;
    logic [DATA_W-1:0]  addr;
    logic [RD_W-1:0]    rd;
    logic [ALUOP_W-1:0] alu_op;
    logic [CTRL_W-1:0]  ctrl;

    modport master (output valid, rs, rt, addr, rd, alu_op, ctrl, input ready);
    modport slave  (input valid, rs, rt, addr, rd, alu_op, ctrl, output ready);
endinterface

// File: rtl/idex_skid_reg_pipe_slot.sv
// Width-parametrised payload register with load enable.
module idex_skid_reg_pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (ld_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/idex_skid_reg.sv
// ID/EX pipeline register: main slot plus one skid slot, flush, gated control, stall counter.
module idex_skid_reg
  import idex_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned RD_W    = DefRdW,
    parameter int unsigned ALUOP_W = DefAluOpW,
    parameter int unsigned CTRL_W  = DefCtrlW,
    parameter int unsigned CNT_W   = DefCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    idex_skid_reg_if.slave   in_if,
    idex_skid_reg_if.master  out_if,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam int unsigned PayW   = payload_w(DATA_W, RD_W, ALUOP_W, CTRL_W);
    localparam int unsigned OffAlu = CTRL_W;
    localparam int unsigned OffRd  = OffAlu + ALUOP_W;
    localparam int unsigned OffAdr = OffRd + RD_W;
    localparam int unsigned OffRt  = OffAdr + DATA_W;
    localparam int unsigned OffRs  = OffRt + DATA_W;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [PayW-1:0]  in_pay, main_pay, skid_pay, main_src;
    logic             main_valid, skid_valid, acc_in, rel_out;
    logic             main_ld, skid_ld, main_from_skid;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];
    // in_ready comes straight from the skid flop, so it never depends on out_ready.
    assign in_if.ready = !skid_valid;
    assign acc_in  = in_if.valid && !skid_valid;
    assign rel_out = main_valid && out_if.ready;

    assign in_pay   = {in_if.rs, in_if.rt, in_if.addr, in_if.rd, in_if.alu_op, in_if.ctrl};
    assign main_src = main_from_skid ? skid_pay : in_pay;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            StEmpty: begin
                if (acc_in) begin
                    main_ld = 1'b1;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (rel_out && acc_in) begin
                    main_ld = 1'b1;
                end else if (rel_out) begin
                    state_d = StEmpty;
                end else if (acc_in) begin
                    skid_ld = 1'b1;
                    state_d = StSkid;
                end
            end
            StSkid: begin
                if (rel_out) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = StFull;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush_i) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (main_valid && !out_if.ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    idex_skid_reg_pipe_slot #(.W(PayW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (main_ld),
        .d_i   (main_src),
        .q_o   (main_pay)
    );

    idex_skid_reg_pipe_slot #(.W(PayW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (skid_ld),
        .d_i   (in_pay),
        .q_o   (skid_pay)
    );

    assign out_if.valid  = main_valid;
    assign out_if.rs     = main_pay[OffRs +: DATA_W];
    assign out_if.rt     = main_pay[OffRt +: DATA_W];
    assign out_if.addr   = main_pay[OffAdr +: DATA_W];
    assign out_if.rd     = main_pay[OffRd +: RD_W];
    assign out_if.alu_op = main_pay[OffAlu +: ALUOP_W];
    // A bubble must never carry live control.
    assign out_if.ctrl   = main_valid ? main_pay[CTRL_W-1:0] : '0;
    assign stall_cnt_o   = stall_q;
endmodule

// File: tb/tb_idex_skid_reg.sv
// Directed bench for idex_skid_reg, built with a 4-bit stall counter to reach saturation.
module tb_idex_skid_reg;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] stall_cnt;
    int               total = 0;
    int               bad = 0;

    idex_skid_reg_if in_b ();
    idex_skid_reg_if out_b ();

    idex_skid_reg #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_if       (in_b),
        .out_if      (out_b),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] rs, input logic [8:0] ctrl);
        in_b.valid  = v;
        in_b.rs     = rs;
        in_b.rt     = ~rs;
        in_b.addr   = rs + 32'h100;
        in_b.rd     = rs[5:0];
        in_b.alu_op = rs[3:0];
        in_b.ctrl   = ctrl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        out_b.ready = 1'b0;
        drive(1'b0, 32'h0, 9'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_b.ready = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 9'h001);
        tick();
        tick();
        total++; if (out_b.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_b.valid); end
        total++; if (out_b.ctrl !== 9'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=000", out_b.ctrl); end
        total++; if (in_b.ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_b.ready); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
        total++; if (out_b.rs !== 32'h0) begin bad++; $display("FAIL reset_rs got=%h want=0", out_b.rs); end
        rst_n = 1'b1;
        tick();
        total++; if (out_b.valid !== 1'b1 || out_b.rs !== 32'hDEADBEEF) begin
            bad++; $display("FAIL first_accept got=%b/%h want=1/deadbeef", out_b.valid, out_b.rs); end
        total++; if (out_b.rt !== 32'h21524110 || out_b.addr !== 32'hDEADBFEF) begin
            bad++; $display("FAIL first_payload got=%h/%h want=21524110/deadbfef", out_b.rt, out_b.addr); end
        drive(1'b0, 32'h0, 9'h0);
        out_b.ready = 1'b1;
        tick();
        total++; if (out_b.valid !== 1'b0 || out_b.ctrl !== 9'h0) begin
            bad++; $display("FAIL drain_empty got=%b/%h want=0/000", out_b.valid, out_b.ctrl); end
    endtask

    task automatic test_stream();
        do_reset();
        out_b.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 9'h003);
            tick();
            total++; if (out_b.valid !== 1'b1 || out_b.rs !== 32'(i) || in_b.ready !== 1'b1) begin
                bad++; $display("FAIL stream_%0d got=%b/%0d/%b want=1/%0d/1", i, out_b.valid,
                                out_b.rs, in_b.ready, i); end
        end
        drive(1'b0, 32'h0, 9'h0);
        tick();
        total++; if (out_b.valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b want=0", out_b.valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 32'hA, 9'h001);
        tick();
        total++; if (out_b.ctrl !== 9'h001) begin bad++; $display("FAIL bp_ctrl got=%h want=001", out_b.ctrl); end
        drive(1'b1, 32'hB, 9'h041);
        tick();
        total++; if (in_b.ready !== 1'b0 || out_b.rs !== 32'hA) begin
            bad++; $display("FAIL bp_skid got=%b/%h want=0/a", in_b.ready, out_b.rs); end
        drive(1'b0, 32'h0, 9'h0);
        tick();
        total++; if (out_b.rs !== 32'hA || stall_cnt !== 4'd2) begin
            bad++; $display("FAIL bp_hold got=%h/%0d want=a/2", out_b.rs, stall_cnt); end
        out_b.ready = 1'b1;
        tick();
        total++; if (out_b.valid !== 1'b1 || out_b.rs !== 32'hB || out_b.ctrl !== 9'h041 || in_b.ready !== 1'b1) begin
            bad++; $display("FAIL bp_second got=%b/%h/%h/%b want=1/b/041/1", out_b.valid, out_b.rs,
                            out_b.ctrl, in_b.ready); end
        tick();
        total++; if (out_b.valid !== 1'b0 || stall_cnt !== 4'd2) begin
            bad++; $display("FAIL bp_done got=%b/%0d want=0/2", out_b.valid, stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h1, 9'h1FF);
        tick();
        drive(1'b1, 32'h2, 9'h1FF);
        tick();
        total++; if (in_b.ready !== 1'b0) begin bad++; $display("FAIL flush_pre got=%b want=0", in_b.ready); end
        flush = 1'b1;
        drive(1'b1, 32'h3, 9'h1FF);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 9'h0);
        total++; if (out_b.valid !== 1'b0 || out_b.ctrl !== 9'h0 || in_b.ready !== 1'b1) begin
            bad++; $display("FAIL flush_skid got=%b/%h/%b want=0/000/1", out_b.valid, out_b.ctrl,
                            in_b.ready); end
        out_b.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_b.valid !== 1'b0) begin bad++; $display("FAIL flush_ghost_%0d got=1 want=0", i); end
        end
        drive(1'b1, 32'h4, 9'h1FF);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h5, 9'h1FF);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 9'h0);
        total++; if (out_b.valid !== 1'b0 || out_b.ctrl !== 9'h0) begin
            bad++; $display("FAIL flush_full got=%b/%h want=0/000", out_b.valid, out_b.ctrl); end
        tick();
        total++; if (out_b.valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=1 want=0"); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 32'h7, 9'h001);
        tick();
        drive(1'b0, 32'h0, 9'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) begin
                total++; if (stall_cnt !== 4'd10) begin bad++; $display("FAIL sat_mid got=%0d want=10", stall_cnt); end
            end
        end
        total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_top got=%0d want=15", stall_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        total++; if (stall_cnt !== 4'd15 || out_b.valid !== 1'b0) begin
            bad++; $display("FAIL sat_flush got=%0d/%b want=15/0", stall_cnt, out_b.valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 32'h11, 9'h1FF);
        tick();
        drive(1'b1, 32'h22, 9'h1FF);
        tick();
        drive(1'b0, 32'h0, 9'h0);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (out_b.valid !== 1'b0 || in_b.ready !== 1'b1 || out_b.ctrl !== 9'h0) begin
            bad++; $display("FAIL async_ctl got=%b/%b/%h want=0/1/000", out_b.valid, in_b.ready,
                            out_b.ctrl); end
        total++; if (stall_cnt !== 4'd0 || out_b.rs !== 32'h0) begin
            bad++; $display("FAIL async_data got=%0d/%h want=0/0", stall_cnt, out_b.rs); end
        #2;
        rst_n = 1'b1;
        out_b.ready = 1'b1;
        tick();
        total++; if (out_b.valid !== 1'b0) begin bad++; $display("FAIL async_after got=1 want=0"); end
    endtask

    initial begin
        out_b.ready = 1'b0;
        drive(1'b0, 32'h0, 9'h0);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idex_skid_reg.md
Name: idex_skid_reg

Overview:
Parametrised ID/EX pipeline register with valid/ready flow control, a 2-entry skid buffer, synchronous flush and a saturating stall counter. It sits between decode and execute. It carries the operand, address, destination and ALU-op payload plus the control bundle. Unlike a plain clocked latch, it can hold a beat under backpressure without losing data. It can also inject a bubble that kills all control side effects.

Parameters:
DATA_W, 32, width of rs/rt/addr operands
RD_W, 6, destination register field width
ALUOP_W, 4, ALU opcode width
CTRL_W, 9, control bundle width; bit order {jump_mem, jump, mem_w, mem_r, pctoreg, memtoreg, branch_neg, branch_z, reg_write} (bit 0 = reg_write)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held beats (branch/jump redirect)
in_valid  in  1  decode presents a beat
in_ready  out  1  stage can accept a beat this cycle
rs  in  DATA_W  operand A
rt  in  DATA_W  operand B
addr  in  DATA_W  immediate/address
rd  in  RD_W  destination register
alu_op  in  ALUOP_W  ALU operation
ctrl  in  CTRL_W  control bundle
out_valid  out  1  execute-side beat valid
out_ready  in  1  execute accepts the beat
rs_out, rt_out, addr_out  out  DATA_W  registered payload
rd_out  out  RD_W  registered destination
alu_op_out  out  ALUOP_W  registered opcode
ctrl_out  out  CTRL_W  registered control, forced 0 when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid&&!out_ready, saturating

Behaviour:
- Reset (rst_n=0, async): out_valid=0, skid empty, in_ready=1, all payload outputs 0, ctrl_out=0, stall_cnt=0. Reset mid-operation drops all held beats immediately.
- Transfer rules: accept = in_valid&&in_ready; release = out_valid&&out_ready.
- in_ready is registered and equals !skid_valid. It is never combinationally dependent on out_ready.
- State EMPTY (out_valid=0):
  - accept → main register loads the input → FULL.
  - Latency is 1 cycle, from the accept edge to out_valid=1.
- State FULL (main valid, skid empty):
  - release and accept: main reloads from the input, stays FULL. Throughput is 1 beat/cycle.
  - release only: → EMPTY.
  - accept only (backpressure): the input loads the skid register → SKID, and in_ready=0 from the next cycle.
  - Neither: hold.
- State SKID (both valid, in_ready=0):
  - release: main loads from skid, skid empties → FULL, and in_ready=1 next cycle.
  - No release: hold.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush.
- flush=1 (synchronous, highest priority below reset):
  - Next state is EMPTY, skid is emptied, in_ready=1.
  - Any beat accepted in the flush cycle is discarded.
  - A release in the same cycle still counts as delivered downstream.
  - Payload registers may keep stale data. ctrl_out reads 0 via gating.
- ctrl_out gating: ctrl_out = out_valid ? main_ctrl : 0. A bubble therefore never writes the register file or memory, and never branches or jumps.
- stall_cnt: +1 on each cycle with out_valid&&!out_ready. It saturates at 2^CNT_W−1, is unaffected by flush, and clears only on reset.
- Encoded state and unused values: valid-bit pair {skid_valid, main_valid}. The pair {1,0} is illegal; it must be unreachable and recovers to EMPTY if ever seen.

Decomposition:
- Shared include idex_defs.vh holds:
  - default widths;
  - CTRL_* bit-index constants for the 9 control bits;
  - the state encodings EMPTY/FULL/SKID.
- The payload concatenation {rs,rt,addr,rd,alu_op,ctrl} is handled as one vector of width 3*DATA_W+RD_W+ALUOP_W+CTRL_W.
- One natural sub-module, pipe_slot: a width-parametrised register with load enable and async active-low reset. It is instantiated twice, for main and skid.

Test Plan:
- Reset with in_valid=1, rs=0xDEADBEEF → out_valid=0, ctrl_out=0, in_ready=1, stall_cnt=0; after release of reset, first accept gives rs_out=0xDEADBEEF one cycle later.
- Streaming, out_ready=1, 8 beats rs=1..8 back to back → out_valid continuous, rs_out=1..8 in order at 1 beat/cycle, in_ready never drops.
- Backpressure: FULL with rs=A, out_ready=0, accept rs=B → in_ready=0 next cycle, rs_out holds A; out_ready=1 → A then B delivered, in_ready=1 again; stall_cnt equals stall cycles.
- Flush in SKID state with ctrl=9'h1FF held, plus simultaneous accept → next cycle out_valid=0, ctrl_out=0, in_ready=1, neither held beat nor new beat ever appears.
- Saturation with CNT_W=4, out_ready=0 for 20 cycles while valid → stall_cnt stops at 15; flush leaves it at 15.
- Async reset asserted mid-cycle in SKID state → outputs clear without waiting for clk edge.
